// File: rtl/triangle_channel.sv
// Triangle-wave APU voice: period timer, 32-step sequencer, linear and length counters.
// Optional build macro TRIANGLE_ULTRASONIC_MUTE_EN suppresses stepping for periods below 2.
module triangle_channel (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable_240hz,
   input  logic       enable_120hz,
   input  logic [7:0] reg_4008,
   input  logic [7:0] reg_400A,
   input  logic [7:0] reg_400B,
   input  logic       reg_change,
   output logic [3:0] tri_out
);

   logic [10:0] period;
   logic [10:0] timer_q, timer_d;
   logic        timer_zero;
   logic        muted;
   logic        step_tick;
   logic [4:0]  idx_q, idx_d;
   logic [6:0]  lin_q, lin_d;
   logic [7:0]  len_q, len_d;
   logic [7:0]  len_lut;
   logic        reload_q, reload_d;
   logic [3:0]  out_q, out_d;
   logic        ctrl;

   assign period = {reg_400B[2:0], reg_400A};
   assign ctrl   = reg_4008[7];

   always_comb begin
      len_lut = '0;
      case (reg_400B[7:3])
         5'd0:  len_lut = 8'd10;
         5'd1:  len_lut = 8'd254;
         5'd2:  len_lut = 8'd20;
         5'd3:  len_lut = 8'd2;
         5'd4:  len_lut = 8'd40;
         5'd5:  len_lut = 8'd4;
         5'd6:  len_lut = 8'd80;
         5'd7:  len_lut = 8'd6;
         5'd8:  len_lut = 8'd160;
         5'd9:  len_lut = 8'd8;
         5'd10: len_lut = 8'd60;
         5'd11: len_lut = 8'd10;
         5'd12: len_lut = 8'd14;
         5'd13: len_lut = 8'd12;
         5'd14: len_lut = 8'd26;
         5'd15: len_lut = 8'd14;
         5'd16: len_lut = 8'd12;
         5'd17: len_lut = 8'd16;
         5'd18: len_lut = 8'd24;
         5'd19: len_lut = 8'd18;
         5'd20: len_lut = 8'd48;
         5'd21: len_lut = 8'd20;
         5'd22: len_lut = 8'd96;
         5'd23: len_lut = 8'd22;
         5'd24: len_lut = 8'd192;
         5'd25: len_lut = 8'd24;
         5'd26: len_lut = 8'd72;
         5'd27: len_lut = 8'd26;
         5'd28: len_lut = 8'd16;
         5'd29: len_lut = 8'd28;
         5'd30: len_lut = 8'd32;
         5'd31: len_lut = 8'd30;
         default: len_lut = '0;
      endcase
   end

   always_comb begin
      timer_zero = (timer_q == '0);
`ifdef TRIANGLE_ULTRASONIC_MUTE_EN
      muted = (period < 11'd2);
`else
      muted = 1'b0;
`endif
      step_tick = timer_zero && !muted;
      timer_d   = timer_zero ? period : timer_q - 11'd1;
   end

   // Gating deliberately looks at the registered counters, not their next values.
   always_comb begin
      idx_d = idx_q;
      if (step_tick && (lin_q != '0) && (len_q != '0))
         idx_d = idx_q + 5'd1;
      out_d = idx_q[4] ? idx_q[3:0] : ~idx_q[3:0];
   end

   always_comb begin
      len_d = len_q;
      if (reg_change)
         len_d = len_lut;
      else if (enable_120hz && !ctrl && (len_q != '0))
         len_d = len_q - 8'd1;
   end

   // A write in the same cycle as a quarter-frame strobe counts as a pending reload.
   always_comb begin
      lin_d    = lin_q;
      reload_d = reload_q;
      if (enable_240hz) begin
         if (reload_q || reg_change)
            lin_d = reg_4008[6:0];
         else if (lin_q != '0)
            lin_d = lin_q - 7'd1;
      end
      if (reg_change)
         reload_d = 1'b1;
      else if (enable_240hz && !ctrl)
         reload_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         timer_q  <= '0;
         idx_q    <= '0;
         lin_q    <= '0;
         len_q    <= '0;
         reload_q <= 1'b0;
         out_q    <= '1;
      end else begin
         timer_q  <= timer_d;
         idx_q    <= idx_d;
         lin_q    <= lin_d;
         len_q    <= len_d;
         reload_q <= reload_d;
         out_q    <= out_d;
      end
   end

   assign tri_out = out_q;

endmodule

// File: tb/tb_triangle_channel.sv
// Directed bench for triangle_channel: cycle model compared every cycle plus literal pins.
module tb_triangle_channel;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable_240hz = 1'b0;
   logic       enable_120hz = 1'b0;
   logic [7:0] reg_4008 = '0;
   logic [7:0] reg_400A = '0;
   logic [7:0] reg_400B = '0;
   logic       reg_change = 1'b0;
   logic [3:0] tri_out;

   int checks = 0;
   int failures = 0;
   bit check_en = 1'b0;

   triangle_channel dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable_240hz (enable_240hz),
      .enable_120hz (enable_120hz),
      .reg_4008     (reg_4008),
      .reg_400A     (reg_400A),
      .reg_400B     (reg_400B),
      .reg_change   (reg_change),
      .tri_out      (tri_out)
   );

   always #5 clk = ~clk;

   int LEN [32] = '{10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,
                    12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30};

   // Model: step phase counted up from the last reload, counters as plain integers.
   int m_elapsed, m_span, m_idx, m_lin, m_len, m_out;
   bit m_flag;

   always @(posedge clk) begin : model
      int  p;
      bit  tick;
      bit  hold;
      if (!rst_n) begin
         m_elapsed = 0; m_span = 0; m_idx = 0; m_lin = 0; m_len = 0;
         m_flag = 0; m_out = 15;
      end else begin
         p    = reg_400B[2:0] * 256 + reg_400A;
         hold = reg_4008[7];
         tick = (m_elapsed == m_span);
         if (tick) begin m_span = p; m_elapsed = 0; end
         else m_elapsed = m_elapsed + 1;
`ifdef TRIANGLE_ULTRASONIC_MUTE_EN
         if (p < 2) tick = 0;
`endif
         m_out = (m_idx < 16) ? 15 - m_idx : m_idx - 16;
         if (tick && m_lin > 0 && m_len > 0) m_idx = (m_idx + 1) % 32;
         if (reg_change) m_len = LEN[reg_400B[7:3]];
         else if (enable_120hz && !hold && m_len > 0) m_len = m_len - 1;
         if (enable_240hz) begin
            if (m_flag || reg_change) m_lin = reg_4008[6:0];
            else if (m_lin > 0) m_lin = m_lin - 1;
         end
         if (reg_change) m_flag = 1;
         else if (enable_240hz && !hold) m_flag = 0;
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         checks++;
         if (int'(tri_out) != m_out) begin
            failures++;
            $display("FAIL model_cmp t=%0t: tri_out=%0d expected %0d", $time, tri_out, m_out);
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic pulse(input bit rc, input bit e120, input bit e240);
      reg_change = rc; enable_120hz = e120; enable_240hz = e240;
      @(negedge clk);
      reg_change = 0; enable_120hz = 0; enable_240hz = 0;
      @(negedge clk);
   endtask

   task automatic wait_change(input string name, input int bound, output int cyc, output int val);
      int prev;
      prev = tri_out; cyc = 0;
      do begin @(negedge clk); cyc++; end while (int'(tri_out) == prev && cyc < bound);
      val = tri_out;
      chk({name, "_stepped"}, int'(int'(tri_out) != prev), 1);
   endtask

   task automatic count_changes(input int n, output int c);
      int prev;
      prev = tri_out; c = 0;
      repeat (n) begin
         @(negedge clk);
         if (int'(tri_out) != prev) c++;
         prev = tri_out;
      end
   endtask

   task automatic wait_enter(input string name, input int v, input int bound);
      int prev, cyc;
      prev = tri_out; cyc = 0;
      do begin
         prev = tri_out; @(negedge clk); cyc++;
      end while (!(int'(tri_out) == v && prev != v) && cyc < bound);
      chk({name, "_reached"}, int'(tri_out), v);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int cyc, val, c, prev;
      bit found;
      repeat (3) @(negedge clk);
      check_en = 1;
      chk("reset_out", tri_out, 15);
      rst_n = 1;

      // Period 0xFF, hold control set, length index 1.
      reg_400A = 8'hFF; reg_400B = 8'h08; reg_4008 = 8'h81;
      pulse(1, 0, 0);
      repeat (600) @(negedge clk);
      chk("t1_gated_before_240", tri_out, 15);
      pulse(0, 0, 1);
      wait_change("t1_first", 400, cyc, val);
      chk("t1_first_val", val, 14);
      wait_change("t1_second", 400, cyc, val);
      chk("t1_interval", cyc, 256);
      chk("t1_second_val", val, 13);
      repeat (8200) @(negedge clk);

      // Length countdown with control clear.
      reg_4008 = 8'h05; reg_400B = 8'h00;
      pulse(1, 0, 0);
      pulse(0, 0, 1);
      repeat (9) pulse(0, 1, 0);
      wait_change("t2_len1", 600, cyc, val);
      pulse(0, 1, 0);
      count_changes(600, c);
      chk("t2_len0_frozen", c, 0);

      // Linear countdown.
      pulse(1, 0, 0);
      pulse(0, 0, 1);
      repeat (4) pulse(0, 0, 1);
      wait_change("t2_lin1", 600, cyc, val);
      pulse(0, 0, 1);
      count_changes(600, c);
      chk("t2_lin0_frozen", c, 0);

      // Halt holds length 254 through 1000 half-frames.
      reg_4008 = 8'h81; reg_400B = 8'h08;
      pulse(1, 0, 0);
      pulse(0, 0, 1);
      repeat (1000) pulse(0, 1, 0);
      reg_4008 = 8'h01;
      repeat (253) pulse(0, 1, 0);
      wait_change("t3_len1", 600, cyc, val);
      pulse(0, 1, 0);
      count_changes(600, c);
      chk("t3_len0_frozen", c, 0);

      // Load beats simultaneous decrement: index 3 gives length 2.
      reg_4008 = 8'h05; reg_400B = 8'h18;
      pulse(1, 1, 0);
      pulse(0, 0, 1);
      pulse(0, 1, 0);
      wait_change("t4_len1", 600, cyc, val);
      pulse(0, 1, 0);
      count_changes(600, c);
      chk("t4_len0_frozen", c, 0);

      // Period 1.
      reg_4008 = 8'h81; reg_400B = 8'h08; reg_400A = 8'h01;
      pulse(1, 0, 0);
      pulse(0, 0, 1);
`ifdef TRIANGLE_ULTRASONIC_MUTE_EN
      repeat (300) @(negedge clk);
      count_changes(200, c);
      chk("t5_muted", c, 0);
`else
      wait_enter("t5_at7", 7, 600);
      wait_change("t5_next", 20, cyc, val);
      chk("t5_interval", cyc, 2);
`endif

      // Reset mid-sequence on the ascending half at index 20.
      reg_400A = 8'h03;
      found = 0; cyc = 0;
      prev = tri_out;
      while (!found && cyc < 3000) begin
         @(negedge clk); cyc++;
         if (tri_out == 4'd4 && prev == 3) found = 1;
         prev = tri_out;
      end
      chk("t6_found_idx20", int'(found), 1);
      rst_n = 0;
      @(negedge clk);
      chk("t6_reset_out", tri_out, 15);
      rst_n = 1;
      count_changes(200, c);
      chk("t6_counters_zero", c, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/triangle_channel.md
# triangle_channel

Triangle-wave voice of the APU, parallel to the rectangle channel. Consumes triangle registers `reg_4008`, `reg_400A` and `reg_400B`, the 240 Hz and 120 Hz frame enables, and the register-change strobe. Produces a 4-bit sample for the mixer and `audio_pwm` stage. Contains:
- an 11-bit period timer,
- a 32-step sequencer,
- a 7-bit linear counter,
- an 8-bit length counter with lookup table.

## Interface
Parameters: none.

Ports (clock and reset first):
- `clk` in 1: APU system clock, ~1.79 MHz.
- `rst_n` in 1: reset, synchronous, active-low; clock `clk`.
- `enable_240hz` in 1: quarter-frame strobe, one `clk` wide.
- `enable_120hz` in 1: half-frame strobe, one `clk` wide.
- `reg_4008` in 8: bit 7 = control (linear hold / length halt); bits 6:0 = linear reload value.
- `reg_400A` in 8: timer period, low 8 bits.
- `reg_400B` in 8: bits 7:3 = length index; bits 2:0 = timer period, high 3 bits.
- `reg_change` in 1: one-`clk` pulse on `clk`, asserted after a register update. Treated as a write to `400B`.
- `tri_out` out 4: triangle sample, 0..15.

## Operation
- Period: P = {`reg_400B[2:0]`, `reg_400A`}, 11 bits, read live.
- Timer:
  - 11-bit down-counter, decremented every `clk`.
  - At 0 it reloads P and emits a step tick.
  - Step rate = clk/(P+1).
- Sequencer:
  - 5-bit index, incremented (mod 32) on a step tick, only if linear ≠ 0 and length ≠ 0. Otherwise it holds.
  - `tri_out` for index 0..15 = 15 − index; for index 16..31 = index − 16.
  - The sequence runs 15..0, 0..15. Output frequency = clk/(32·(P+1)).
  - When gated, `tri_out` holds its last value. It never forces 0.
- Length counter (8-bit):
  - On `reg_change`: load LEN[`reg_400B[7:3]`].
  - Otherwise, on `enable_120hz`: if `reg_4008[7]`=0 and the count ≠ 0, decrement.
  - The count saturates at 0.
- LEN table, index 0..31: 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
- Reload flag:
  - `reg_change` sets it.
  - Each `enable_240hz` clears it when `reg_4008[7]`=0.
- Linear counter (7-bit), on `enable_240hz`:
  - If the reload flag is set: load `reg_4008[6:0]`.
  - Else, if the count ≠ 0: decrement.
  - It never underflows.
- Simultaneous events:
  - `reg_change` and `enable_120hz` in the same cycle: the load wins and no decrement occurs.
  - `reg_change` and `enable_240hz` in the same cycle: the linear counter loads `reg_4008[6:0]` and the reload flag ends that cycle set.
  - A timer step tick in the same cycle as a counter reaching 0: gating uses the counter values registered before that edge.
- Changing P mid-count does not disturb the current countdown. The new P takes effect at the next reload.

## Timing
- Reset (`rst_n`=0 at a `clk` edge):
  - timer = 0, index = 0, linear = 0, length = 0, reload flag = 0.
  - `tri_out` = 4'hF.
- Reset mid-operation is immediate on that edge. Registers have no reset-exempt state.
- `tri_out` is registered from the index and changes one `clk` after the step tick edge.
- Counter updates take effect on the edge where the strobe is sampled high.

## Configuration
- Macro: `TRIANGLE_ULTRASONIC_MUTE_EN`.
- Defined: when P < 2, step ticks are suppressed and `tri_out` holds. This avoids an ultrasonic pop into the PWM.
- Undefined: P = 0 and P = 1 step every 1 or 2 `clk` cycles, like any other period.

## Test plan
- Reset, then P=0x0FF, `reg_4008`=0x81, `400B` index 1 plus `reg_change` → `tri_out`=15 until the first 240 Hz strobe loads linear=1. Thereafter `tri_out` steps every 256 `clk`, sequence 15,14,…,0,0,1,…,15; period 8192 `clk`.
- `reg_4008`=0x05 (control=0), `400B` index 0 (LEN 10) plus `reg_change`:
  - Linear loads 5 on the first 240 Hz strobe, reaches 0 after five more strobes, then `tri_out` freezes at its current value.
  - Length reaches 0 after 10 half-frame strobes.
- `reg_4008[7]`=1 with length loaded 254 → length stays 254 across 1000 `enable_120hz` strobes.
- `reg_change` and `enable_120hz` in the same cycle with index 3 → length = 2, not 1.
- P=1: with `TRIANGLE_ULTRASONIC_MUTE_EN` defined, `tri_out` is constant. Without it, `tri_out` steps every 2 `clk`.
- Assert `rst_n`=0 for one cycle mid-sequence at index 20 → next cycle `tri_out`=15, and all counters read 0.
